// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: sequences fetch/decode/execute/writeback
// and drives ALUOp, datapath mux selects and write strobes from the opcode.
module main_fsm #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic               Branch,
  output logic               PCUpdate,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               AdrSrc,
  output logic [1:0]         ALUOp,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  state_t state, next;
  logic   ready;

  assign ready     = USE_MEM_READY ? mem_ready : 1'b1;
  assign state_dbg = STATE_W'(state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= next;
  end

  // FETCH strobes also depend on reset_n so nothing fires while reset is held.
  always_comb begin
    next       = FETCH;
    Branch     = 1'b0;
    PCUpdate   = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    AdrSrc     = 1'b0;
    ALUOp      = 2'b00;
    illegal_op = 1'b0;
    case (state)
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECR;
          OP_I:         next = EXECI;
          OP_JAL:       next = JAL;
          OP_BEQ:       next = BEQ;
          default:      next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = reset_n;
        next     = ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        next    = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        next    = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
        next     = ALUWB;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
        // FETCH and any unused encoding
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ready & reset_n;
        PCUpdate  = ready & reset_n;
        next      = ready ? DECODE : FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: the driver queues the expected per-cycle
// outputs, an independent monitor pops and compares them on the falling edge.
module tb_main_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       branch;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       adr_src;
    logic [1:0] alu_op;
  } outs_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'b0;
  logic       mem_ready = 1'b1;
  logic       Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state_dbg;

  outs_t exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  main_fsm #(.USE_MEM_READY(1'b1), .STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .Branch(Branch), .PCUpdate(PCUpdate), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AdrSrc(AdrSrc), .ALUOp(ALUOp),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Hand-transcribed per-state output table: {st, Br, PCU, RW, MW, IRW, Ill, Res, A, B, Adr, Op}
  function automatic outs_t expected(input int st, input logic rdy, input logic rst_n);
    logic f;
    f = rdy & rst_n;
    case (st)
      0:  expected = {4'd0,  1'b0, f,    1'b0, 1'b0, f,    1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00};
      1:  expected = {4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00};
      2:  expected = {4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00};
      3:  expected = {4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
      4:  expected = {4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00};
      5:  expected = {4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
      6:  expected = {4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10};
      8:  expected = {4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
      9:  expected = {4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00};
      10: expected = {4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b01};
      11: expected = {4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
      default: expected = '1;
    endcase
  endfunction

  task automatic apply_stimulus(input string tag, input logic rst_n, input logic [6:0] op_v,
                                input logic rdy, input int st);
    @(posedge clk);
    #1;
    reset_n   = rst_n;
    op        = op_v;
    mem_ready = rdy;
    exp_q.push_back(expected(st, rdy, rst_n));
    tag_q.push_back(tag);
  endtask

  task automatic check_output(input string tag, input outs_t exp_v);
    outs_t act;
    act = {state_dbg, Branch, PCUpdate, RegWrite, MemWrite, IRWrite, illegal_op,
           ResultSrc, ALUSrcA, ALUSrcB, AdrSrc, ALUOp};
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %05h (state %0d) expected %05h (state %0d)",
               tag, act, act.st, exp_v, exp_v.st);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check_output(tag_q.pop_front(), exp_q.pop_front());
  end

  initial begin
    for (int i = 0; i < 3; i++) apply_stimulus("reset", 1'b0, 7'h00, 1'b1, 0);
    apply_stimulus("post_reset_fetch", 1'b1, 7'h00, 1'b1, 0);

    apply_stimulus("lw_decode",  1'b1, LW, 1'b1, 1);
    apply_stimulus("lw_memadr",  1'b1, LW, 1'b1, 2);
    apply_stimulus("lw_memread", 1'b1, LW, 1'b1, 3);
    apply_stimulus("lw_memwb",   1'b1, LW, 1'b1, 4);
    apply_stimulus("lw_fetch",   1'b1, LW, 1'b1, 0);

    apply_stimulus("sw_decode",  1'b1, SW, 1'b1, 1);
    apply_stimulus("sw_memadr",  1'b1, SW, 1'b1, 2);
    for (int i = 0; i < 3; i++) apply_stimulus("sw_stall", 1'b1, SW, 1'b0, 5);
    apply_stimulus("sw_accept",  1'b1, SW, 1'b1, 5);
    apply_stimulus("sw_fetch",   1'b1, SW, 1'b1, 0);

    apply_stimulus("r_decode",   1'b1, RT,  1'b1, 1);
    apply_stimulus("r_exec",     1'b1, BAD, 1'b1, 6);
    apply_stimulus("r_aluwb",    1'b1, BAD, 1'b1, 8);
    apply_stimulus("r_fetch",    1'b1, BAD, 1'b1, 0);

    apply_stimulus("beq_decode", 1'b1, BQ, 1'b1, 1);
    apply_stimulus("beq_exec",   1'b1, BQ, 1'b1, 10);
    apply_stimulus("beq_fetch",  1'b1, BQ, 1'b1, 0);

    apply_stimulus("jal_decode", 1'b1, JL, 1'b1, 1);
    apply_stimulus("jal_exec",   1'b1, JL, 1'b1, 9);
    apply_stimulus("jal_aluwb",  1'b1, JL, 1'b1, 8);
    apply_stimulus("jal_fetch",  1'b1, JL, 1'b1, 0);

    apply_stimulus("ill_decode", 1'b1, BAD, 1'b1, 1);
    apply_stimulus("ill_pulse",  1'b1, BAD, 1'b1, 11);
    apply_stimulus("ill_fetch",  1'b1, BAD, 1'b1, 0);

    apply_stimulus("lw2_decode",  1'b1, LW, 1'b1, 1);
    apply_stimulus("lw2_memadr",  1'b1, LW, 1'b1, 2);
    apply_stimulus("lw2_memread", 1'b1, LW, 1'b0, 3);
    apply_stimulus("lw2_stall",   1'b1, LW, 1'b0, 3);
    apply_stimulus("mid_reset",   1'b0, LW, 1'b1, 0);
    apply_stimulus("mid_reset_hold", 1'b0, LW, 1'b1, 0);
    apply_stimulus("fetch_stall", 1'b1, LW, 1'b0, 0);
    apply_stimulus("fetch_stall2", 1'b1, LW, 1'b0, 0);
    apply_stimulus("fetch_go",    1'b1, LW, 1'b1, 0);
    apply_stimulus("lw3_decode",  1'b1, LW, 1'b1, 1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle RISC-V control FSM; produces ALUOp plus all datapath mux selects and write strobes from the instruction opcode.
- Its ALUOp output drives the existing ALU decoder, which turns it into ALUControl.
- Sits in the controller beside that decoder and the branch-gating logic (PCWrite = PCUpdate | (Branch & Zero), built outside this block).
- Supports lw, sw, R-type, I-type ALU, jal, beq; memory accesses stall on a ready handshake.

Parameters:
- USE_MEM_READY, 1: when 1, mem_ready is honoured; when 0, mem_ready is ignored and treated as constant 1.
- STATE_W, 4: width of the state register and of the state_dbg port. Must be at least 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode field from the instruction register, stable after Fetch.
- mem_ready  in  1  memory has completed the current fetch, load or store this cycle.
- Branch  out  1  conditional-branch cycle.
- PCUpdate  out  1  unconditional PC write.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write request.
- IRWrite  out  1  instruction register load.
- ResultSrc  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  out  2  ALU B select: 00 rs2, 01 ImmExt, 10 constant 4.
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut.
- ALUOp  out  2  to ALU decoder: 00 add, 01 sub, 10 decode funct fields.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- state_dbg  out  STATE_W  current state encoding.

Behaviour:
- State register updates on rising clk; reset_n low forces it asynchronously to FETCH.
- While reset_n is 0, all strobes (Branch, PCUpdate, RegWrite, MemWrite, IRWrite, illegal_op) are 0; selects take FETCH values; state_dbg is 0.
- Outputs are Moore (from state only), except the FETCH strobes, which are gated by mem_ready.
- Any output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BEQ=10, ILLEGAL=11.
- Per-state outputs and next state:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=mem_ready. Next is DECODE if mem_ready, else stay in FETCH.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - anything else -> ILLEGAL
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next is MEMWB if mem_ready, else stay.
  - MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until accepted. Next is FETCH if mem_ready, else stay.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next is ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next is FETCH.
  - ILLEGAL: illegal_op=1 for exactly one cycle. Next is FETCH.
  - Unused encodings: behave as FETCH and transition to FETCH.
- Cycle counts with mem_ready constantly 1:
  - lw = 5 cycles; sw = 4; R-type, I-type and jal = 4; beq = 3; illegal opcode = 3.
- Each stalled cycle holds the state and all outputs, with FETCH strobes kept at 0.
- Reset asserted mid-instruction: immediate return to FETCH. No partial RegWrite or MemWrite pulse may appear after reset_n falls.
- op is only sampled in DECODE and MEMADR; changes to op in other states have no effect.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, then release with mem_ready=1. Expect state_dbg 0, all strobes 0 during reset; IRWrite=PCUpdate=1 in the first post-reset cycle; state_dbg=1 next.
- lw (op=0000011), mem_ready=1: state_dbg sequence 0,1,2,3,4,0. RegWrite=1 and ResultSrc=01 only in state 4. AdrSrc=1 in state 3.
- sw with mem_ready=0 for 3 cycles in MEMWRITE: MemWrite=1 for 4 consecutive cycles, then state returns to 0. RegWrite never asserts.
- R-type (0110011) then beq (1100011): ALUOp=10 in state 6, then RegWrite in state 8. For beq, Branch=1 and ALUOp=01 in state 10, and PCUpdate=0 throughout state 10.
- jal (1101111): state sequence 0,1,9,8,0. PCUpdate=1 in state 9 with ALUSrcA=01, ALUSrcB=10.
- Illegal op=1111111: state sequence 0,1,11,0. illegal_op high exactly one cycle. Also pull reset_n low during state 3 of a lw: state is 0 immediately and no RegWrite pulse appears.
